// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the decode-to-execute bus together with everything the
// execute stage drives back out (MEM bus, decode forwarding, data SRAM request).
//   master : the decode side / environment; drives id_to_ex_bus, observes the rest
//   slave  : the execute stage; consumes id_to_ex_bus, drives the rest
interface ex_stage_if #(
  parameter int ID_TO_EX_WD  = 164,
  parameter int EX_TO_MEM_WD = 78
);
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [37:0]             ex_to_rf_bus;
  logic                    ex_is_load;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;

  modport master (
    output id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_rf_bus, ex_is_load,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  id_to_ex_bus,
    output ex_to_mem_bus, ex_to_rf_bus, ex_is_load,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Holds the ID/EX pipeline register, runs the ALU, issues the data SRAM
// request and forwards results to MEM and back to decode.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   stall      : pipeline stall vector (bit 2 = ID, bit 3 = EX, 1 = stop)
//   bus        : ex_stage_if.slave carrying id_to_ex_bus in, and
//                ex_to_mem_bus, ex_to_rf_bus, ex_is_load, data_sram_* out
module ex_stage #(
  parameter int ID_TO_EX_WD  = 164,
  parameter int EX_TO_MEM_WD = 78,
  parameter int STALL_WD     = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STALL_WD-1:0] stall,
  ex_stage_if.slave           bus
);

  logic [ID_TO_EX_WD-1:0] id_ex_q, id_ex_d;

  // Bubble when decode stops but execute moves on, so the slot left behind
  // carries no register write or memory request; otherwise follow decode.
  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[2] && !stall[3]) begin
      id_ex_d = '0;
    end else if (!stall[2]) begin
      id_ex_d = bus.id_to_ex_bus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  logic [4:0]  mem_op;
  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign mem_op     = id_ex_q[163:159];
  assign pc         = id_ex_q[158:127];
  assign inst       = id_ex_q[126:95];
  assign alu_op     = id_ex_q[94:83];
  assign sel_src1   = id_ex_q[82:80];
  assign sel_src2   = id_ex_q[79:76];
  assign ram_en     = id_ex_q[75];
  assign ram_wen    = id_ex_q[74:71];
  assign rf_we      = id_ex_q[70];
  assign rf_waddr   = id_ex_q[69:65];
  assign sel_rf_res = id_ex_q[64];
  assign rdata1     = id_ex_q[63:32];
  assign rdata2     = id_ex_q[31:0];

  logic [31:0] imm_sext, imm_zext, src1, src2, alu_res, mem_addr;
  logic [4:0]  sa;

  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};

  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});

  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & imm_sext)
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & imm_zext);

  assign sa = src1[4:0];

  // One-hot op select; several ops at once simply OR together.
  assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                 | ({32{alu_op[10]}} & (src1 - src2))
                 | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & (src2 << sa))
                 | ({32{alu_op[2]}}  & (src2 >> sa))
                 | ({32{alu_op[1]}}  & 32'($signed(src2) >>> sa))
                 | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

  // Memory address has its own adder so the ALU op choice never affects it.
  assign mem_addr = rdata1 + imm_sext;

  logic [3:0]  store_wen;
  logic [31:0] store_wdata;

  // ram_wen field is {-, sb, sh, sw}; wider stores win. Low address bits that
  // a store width cannot use are ignored rather than trapped.
  always_comb begin
    store_wen   = 4'b0000;
    store_wdata = 32'b0;
    if (ram_wen[0]) begin
      store_wen   = 4'b1111;
      store_wdata = rdata2;
    end else if (ram_wen[1]) begin
      store_wen   = mem_addr[1] ? 4'b1100 : 4'b0011;
      store_wdata = {2{rdata2[15:0]}};
    end else if (ram_wen[2]) begin
      store_wen   = 4'b0001 << mem_addr[1:0];
      store_wdata = {4{rdata2[7:0]}};
    end
  end

  // The request only goes out in the cycle EX advances, so a store held
  // across a stall is written exactly once.
  logic ex_go;
  assign ex_go = !stall[3];

  assign bus.data_sram_en    = (ram_en | (|store_wen) | (|mem_op)) & ex_go;
  assign bus.data_sram_wen   = ex_go ? store_wen : 4'b0000;
  assign bus.data_sram_addr  = mem_addr;
  assign bus.data_sram_wdata = store_wdata;

  assign bus.ex_is_load    = (|mem_op) | sel_rf_res;
  assign bus.ex_to_rf_bus  = {rf_we, rf_waddr, alu_res};
  assign bus.ex_to_mem_bus = EX_TO_MEM_WD'({mem_op, pc, rf_we, rf_waddr,
                                            sel_rf_res, alu_res, mem_addr[1:0]});

  logic unused_ok;
  assign unused_ok = &{1'b0, stall[STALL_WD-1:4], stall[1:0], inst[31:16], ram_wen[3]};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. Stimulus pushes the expected
// EX outputs for each cycle into a queue; a monitor on the falling edge pops
// and compares against what the DUT presents.
module tb_ex_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] stall;

  ex_stage_if ex_if ();

  ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .bus   (ex_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [77:0] mem_bus;
    logic [37:0] rf_bus;
    logic        is_load;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  logic [163:0] held;
  bit           mon_en = 0;

  function automatic logic [163:0] mk(
    input logic [4:0] mem_op, input logic [31:0] pc, input logic [31:0] inst,
    input logic [11:0] alu_op, input logic [2:0] s1, input logic [3:0] s2,
    input logic ram_en, input logic [3:0] ram_wen, input logic rf_we,
    input logic [4:0] waddr, input logic sel_rf, input logic [31:0] r1,
    input logic [31:0] r2);
    return {mem_op, pc, inst, alu_op, s1, s2, ram_en, ram_wen, rf_we, waddr, sel_rf, r1, r2};
  endfunction

  // Reference: what EX should present given the instruction it holds and
  // whether EX is stopped this cycle.
  function automatic exp_t model(input logic [163:0] b, input logic stall_ex);
    exp_t        e;
    logic [31:0] pc, inst, r1, r2, a, c, res, imm_s, addr, ones;
    logic [31:0] r [12];
    logic [11:0] alu_op;
    logic [2:0]  s1;
    logic [3:0]  s2, ram_wen;
    logic [4:0]  mem_op, sh;
    int          size, base;
    mem_op  = b[163:159];
    pc      = b[158:127];
    inst    = b[126:95];
    alu_op  = b[94:83];
    s1      = b[82:80];
    s2      = b[79:76];
    ram_wen = b[74:71];
    r1      = b[63:32];
    r2      = b[31:0];
    imm_s   = {{16{inst[15]}}, inst[15:0]};
    ones    = 32'hFFFF_FFFF;
    a = 32'd0;
    if (s1[0]) a = a | r1;
    if (s1[1]) a = a | pc;
    if (s1[2]) a = a | 32'(inst[10:6]);
    c = 32'd0;
    if (s2[0]) c = c | r2;
    if (s2[1]) c = c | imm_s;
    if (s2[2]) c = c | 32'd8;
    if (s2[3]) c = c | 32'(inst[15:0]);
    sh    = a[4:0];
    r[11] = a + c;
    r[10] = a - c;
    r[9]  = (a[31] != c[31]) ? 32'(a[31]) : 32'(a < c);
    r[8]  = 32'(a < c);
    r[7]  = a & c;
    r[6]  = ~(a | c);
    r[5]  = a | c;
    r[4]  = a ^ c;
    r[3]  = c << sh;
    r[2]  = c >> sh;
    r[1]  = (c >> sh) | (c[31] ? ~(ones >> sh) : 32'd0);
    r[0]  = c << 16;
    res = 32'd0;
    for (int i = 0; i < 12; i++) if (alu_op[i]) res = res | r[i];
    addr = r1 + imm_s;
    size = ram_wen[0] ? 4 : ram_wen[1] ? 2 : ram_wen[2] ? 1 : 0;
    e.wen   = 4'b0;
    e.wdata = 32'b0;
    if (size > 0) begin
      base = (size == 4) ? 0 : (size == 2) ? 2 * int'(addr[1]) : int'(addr[1:0]);
      for (int l = base; l < base + size; l++) e.wen[l] = 1'b1;
      for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = r2[8*(j % size) +: 8];
    end
    e.en      = (b[75] || e.wen != 0 || mem_op != 0) && !stall_ex;
    if (stall_ex) e.wen = 4'b0;
    e.addr    = addr;
    e.is_load = (mem_op != 0) || b[64];
    e.rf_bus  = {b[70], b[69:65], res};
    e.mem_bus = {mem_op, pc, b[70], b[69:65], b[64], res, addr[1:0]};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [77:0] actual,
                             input logic [77:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle, record what EX must show during it, then advance the
  // model's copy of the pipeline register the way the edge should.
  task automatic applyStimulus(input logic [163:0] b, input logic [5:0] s);
    ex_if.id_to_ex_bus = b;
    stall = s;
    exp_q.push_back(model(held, s[3]));
    if (s[2] && !s[3]) held = '0;
    else if (!s[2]) held = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_empty", 78'd1, 78'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("ex_to_mem_bus", ex_if.ex_to_mem_bus, mon_e.mem_bus);
          checkOutput("ex_to_rf_bus", 78'(ex_if.ex_to_rf_bus), 78'(mon_e.rf_bus));
          checkOutput("ex_is_load", 78'(ex_if.ex_is_load), 78'(mon_e.is_load));
          checkOutput("data_sram_en", 78'(ex_if.data_sram_en), 78'(mon_e.en));
          checkOutput("data_sram_wen", 78'(ex_if.data_sram_wen), 78'(mon_e.wen));
          checkOutput("data_sram_addr", 78'(ex_if.data_sram_addr), 78'(mon_e.addr));
          checkOutput("data_sram_wdata", 78'(ex_if.data_sram_wdata), 78'(mon_e.wdata));
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_bus"}, ex_if.ex_to_mem_bus, 78'd0);
    checkOutput({tag, "_rf_bus"}, 78'(ex_if.ex_to_rf_bus), 78'd0);
    checkOutput({tag, "_is_load"}, 78'(ex_if.ex_is_load), 78'd0);
    checkOutput({tag, "_en"}, 78'(ex_if.data_sram_en), 78'd0);
    checkOutput({tag, "_wen"}, 78'(ex_if.data_sram_wen), 78'd0);
    checkOutput({tag, "_addr"}, 78'(ex_if.data_sram_addr), 78'd0);
    checkOutput({tag, "_wdata"}, 78'(ex_if.data_sram_wdata), 78'd0);
  endtask

  logic [163:0] b_add, b_sb, b_sh0, b_sh1, b_sw, b_jal, b_lui, b_sra, b_slt, b_sltu, b_lw, rb;
  logic [11:0]  rop;
  exp_t         pre;

  initial begin
    rst_n = 1'b0;
    stall = 6'b0;
    ex_if.id_to_ex_bus = '0;
    held = '0;

    b_add  = mk(5'd0, 32'h0040_0000, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'b0000, 1'b1, 5'd5, 1'b0, 32'h7FFF_FFFF, 32'd1);
    b_sb   = mk(5'd0, 32'h0040_0004, 32'h0000_0003, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b0100, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'h1234_56AB);
    b_sh0  = mk(5'd0, 32'h0040_0008, 32'h0000_0000, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b0010, 1'b0, 5'd0, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    b_sh1  = mk(5'd0, 32'h0040_000C, 32'h0000_FFFE, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b0010, 1'b0, 5'd0, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    b_sw   = mk(5'd0, 32'h0040_0010, 32'h0000_0010, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b0001, 1'b0, 5'd0, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF);
    b_jal  = mk(5'd0, 32'hBFC0_0000, 32'h0C00_0000, 12'h800, 3'b010, 4'b0100, 1'b0, 4'b0000, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0);
    b_lui  = mk(5'd0, 32'h0040_0014, 32'h3C01_1234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'b0000, 1'b1, 5'd1, 1'b0, 32'h0, 32'h0);
    b_sra  = mk(5'd0, 32'h0040_0018, 32'h0000_0103, 12'h002, 3'b100, 4'b0001, 1'b0, 4'b0000, 1'b1, 5'd2, 1'b0, 32'h0, 32'h8000_0000);
    b_slt  = mk(5'd0, 32'h0040_001C, 32'h0, 12'h200, 3'b001, 4'b0001, 1'b0, 4'b0000, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'd1);
    b_sltu = mk(5'd0, 32'h0040_0020, 32'h0, 12'h100, 3'b001, 4'b0001, 1'b0, 4'b0000, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1);
    b_lw   = mk(5'b00001, 32'h0040_0024, 32'h0000_0004, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b0000, 1'b1, 5'd6, 1'b1, 32'h0000_4000, 32'h5555_5555);

    #12;
    checkAllZero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    applyStimulus(b_add, 6'b000000);
    applyStimulus(b_sb, 6'b000000);
    applyStimulus(b_sb, 6'b001000);
    applyStimulus(b_sh0, 6'b000000);
    applyStimulus(b_sh1, 6'b000000);
    applyStimulus(b_sw, 6'b000000);
    for (int i = 0; i < 3; i++) applyStimulus(b_add, 6'b001100);
    applyStimulus(b_add, 6'b000000);
    applyStimulus(b_jal, 6'b000100);
    applyStimulus(b_jal, 6'b000000);
    applyStimulus(b_lui, 6'b000000);
    applyStimulus(b_sra, 6'b000000);
    applyStimulus(b_slt, 6'b000000);
    applyStimulus(b_sltu, 6'b000000);
    applyStimulus(b_lw, 6'b000000);
    applyStimulus(b_sw, 6'b000000);

    for (int n = 0; n < 400; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'd1 << $urandom_range(0, 11);
      rb = mk(5'($urandom), $urandom, $urandom, rop, 3'($urandom), 4'($urandom),
              1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom), 5'($urandom),
              1'($urandom), $urandom, $urandom);
      applyStimulus(rb, {2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 2'($urandom)});
    end

    applyStimulus(b_sw, 6'b000000);
    applyStimulus(b_sw, 6'b000000);
    mon_en = 0;
    checkOutput("scoreboard_drained", 78'(exp_q.size()), 78'd0);

    // Reset arrives in the middle of an EX stall while a store is held.
    stall = 6'b001100;
    #1;
    pre = model(held, 1'b1);
    checkOutput("pre_reset_addr", 78'(ex_if.data_sram_addr), 78'(pre.addr));
    checkOutput("pre_reset_en_stalled", 78'(ex_if.data_sram_en), 78'd0);
    stall = 6'b000000;
    #1;
    checkOutput("pre_reset_en", 78'(ex_if.data_sram_en), 78'd1);
    stall = 6'b001100;
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    stall = 6'b000000;
    #1;
    checkOutput("async_reset_en_unstalled", 78'(ex_if.data_sram_en), 78'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
